// File: rtl/ref_reader_arbiter.sv
// Round-robin share of one DRAM reference reader among NUM_ENGINES engines; 0-cycle accept/stream paths, issue 1 cycle after accept.
// Non-granted requests and surplus reader blocks are held off (rdy low); optional watchdog via `define REF_ARB_WATCHDOG_EN.
module ref_reader_arbiter #(
   parameter int NUM_ENGINES = 4,
   parameter int REF_LENGTH  = 128,
   parameter int ID_W        = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [25*NUM_ENGINES-1:0] eng_ref_addr_in,
   input  logic [25*NUM_ENGINES-1:0] eng_ref_length_in,
   input  logic [NUM_ENGINES-1:0]    eng_ref_info_valid_in,
   output logic [NUM_ENGINES-1:0]    eng_ref_info_rdy_out,
   output logic [2*REF_LENGTH-1:0]   eng_ref_seq_block_out,
   output logic [NUM_ENGINES-1:0]    eng_ref_seq_block_valid_out,
   input  logic [NUM_ENGINES-1:0]    eng_ref_seq_block_rdy_in,
   output logic [24:0]               ref_addr_out,
   output logic [24:0]               ref_length_out,
   output logic                      ref_info_valid_out,
   input  logic                      ref_info_rdy_in,
   input  logic [2*REF_LENGTH-1:0]   ref_seq_block_in,
   input  logic                      ref_seq_block_valid_in,
   output logic                      ref_seq_block_rdy_out,
   output logic [ID_W-1:0]           grant_id_out,
   output logic                      busy_out,
   output logic                      timeout_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] grant_q, grant_d;
   logic [24:0]     addr_q, addr_d;
   logic [24:0]     len_q, len_d;
   logic [24:0]     cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic [ID_W-1:0] win;
   logic            found;
   logic [ID_W-1:0] grant_nxt;
   logic            hs;
   int              idx;

`ifdef REF_ARB_WATCHDOG_EN
   logic [15:0]     wd_q, wd_d;
   logic            timeout_q, timeout_d;
`endif

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_ENGINES; k++) begin
         idx = (int'(ptr_q) + k) % NUM_ENGINES;
         if (!found && eng_ref_info_valid_in[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   assign grant_nxt = (grant_q == ID_W'(NUM_ENGINES - 1)) ? '0 : grant_q + 1'b1;
   assign hs = (state_q == STREAM) && ref_seq_block_valid_in && eng_ref_seq_block_rdy_in[grant_q];

   always_comb begin
      state_d                     = state_q;
      ptr_d                       = ptr_q;
      grant_d                     = grant_q;
      addr_d                      = addr_q;
      len_d                       = len_q;
      cnt_d                       = cnt_q;
      eng_ref_info_rdy_out        = '0;
      eng_ref_seq_block_out       = '0;
      eng_ref_seq_block_valid_out = '0;
      ref_info_valid_out          = 1'b0;
      ref_seq_block_rdy_out       = 1'b0;
`ifdef REF_ARB_WATCHDOG_EN
      wd_d                        = wd_q;
      timeout_d                   = timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               eng_ref_info_rdy_out[win] = 1'b1;
               grant_d = win;
               addr_d  = eng_ref_addr_in[25*int'(win) +: 25];
               len_d   = eng_ref_length_in[25*int'(win) +: 25];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            ref_info_valid_out = 1'b1;
            if (ref_info_rdy_in) begin
               if (len_q == 25'd0) begin
                  state_d = IDLE;
                  ptr_d   = grant_nxt;
               end else begin
                  cnt_d   = '0;
                  state_d = STREAM;
`ifdef REF_ARB_WATCHDOG_EN
                  wd_d    = '0;
`endif
               end
            end
         end
         STREAM: begin
            eng_ref_seq_block_out                = ref_seq_block_in;
            eng_ref_seq_block_valid_out[grant_q] = ref_seq_block_valid_in;
            ref_seq_block_rdy_out                = eng_ref_seq_block_rdy_in[grant_q];
            if (hs) begin
               cnt_d = cnt_q + 25'd1;
               if (cnt_q == len_q - 25'd1) begin
                  state_d = IDLE;
                  ptr_d   = grant_nxt;
               end
`ifdef REF_ARB_WATCHDOG_EN
               wd_d = '0;
            end else if (wd_q == 16'hFFFF) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
               ptr_d     = grant_nxt;
            end else begin
               wd_d = wd_q + 16'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
`ifdef REF_ARB_WATCHDOG_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
`ifdef REF_ARB_WATCHDOG_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign ref_addr_out   = addr_q;
   assign ref_length_out = len_q;
   assign grant_id_out   = grant_q;
   assign busy_out       = busy_q;
`ifdef REF_ARB_WATCHDOG_EN
   assign timeout_out    = timeout_q;
`else
   assign timeout_out    = 1'b0;
`endif

endmodule

// File: tb/tb_ref_reader_arbiter.sv
// Bench for ref_reader_arbiter: transaction table, reset/back-pressure sequences, random traffic vs a reference model.
module tb_ref_reader_arbiter;
   localparam int N  = 4;
   localparam int BW = 256;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [25*N-1:0] eng_ref_addr_in = '0;
   logic [25*N-1:0] eng_ref_length_in = '0;
   logic [N-1:0]    eng_ref_info_valid_in = '0;
   logic [N-1:0]    eng_ref_info_rdy_out;
   logic [BW-1:0]   eng_ref_seq_block_out;
   logic [N-1:0]    eng_ref_seq_block_valid_out;
   logic [N-1:0]    eng_ref_seq_block_rdy_in = '0;
   logic [24:0]     ref_addr_out;
   logic [24:0]     ref_length_out;
   logic            ref_info_valid_out;
   logic            ref_info_rdy_in = 1'b0;
   logic [BW-1:0]   ref_seq_block_in = '0;
   logic            ref_seq_block_valid_in = 1'b0;
   logic            ref_seq_block_rdy_out;
   logic [1:0]      grant_id_out;
   logic            busy_out;
   logic            timeout_out;

   int checks = 0;
   int errors = 0;

   ref_reader_arbiter #(.NUM_ENGINES(N), .REF_LENGTH(128), .ID_W(2)) dut (
      .clk(clk), .rst(rst),
      .eng_ref_addr_in(eng_ref_addr_in), .eng_ref_length_in(eng_ref_length_in),
      .eng_ref_info_valid_in(eng_ref_info_valid_in), .eng_ref_info_rdy_out(eng_ref_info_rdy_out),
      .eng_ref_seq_block_out(eng_ref_seq_block_out), .eng_ref_seq_block_valid_out(eng_ref_seq_block_valid_out),
      .eng_ref_seq_block_rdy_in(eng_ref_seq_block_rdy_in),
      .ref_addr_out(ref_addr_out), .ref_length_out(ref_length_out),
      .ref_info_valid_out(ref_info_valid_out), .ref_info_rdy_in(ref_info_rdy_in),
      .ref_seq_block_in(ref_seq_block_in), .ref_seq_block_valid_in(ref_seq_block_valid_in),
      .ref_seq_block_rdy_out(ref_seq_block_rdy_out),
      .grant_id_out(grant_id_out), .busy_out(busy_out), .timeout_out(timeout_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic rand_block(output logic [BW-1:0] d);
      for (int k = 0; k < BW/32; k++) d[32*k +: 32] = $urandom();
   endtask

   task automatic set_eng(input logic [N-1:0] mask, input logic [24:0] len, input logic [24:0] base);
      for (int i = 0; i < N; i++) begin
         eng_ref_addr_in[25*i +: 25]   = base + 25'(i*16);
         eng_ref_length_in[25*i +: 25] = len;
      end
      eng_ref_info_valid_in = mask;
   endtask

   // One full transaction with the reader always valid; optional toggling engine ready.
   task automatic do_txn(input logic [N-1:0] mask, input logic [24:0] len, input logic [24:0] base,
                         input int g, input bit toggle);
      logic [N-1:0]  oh;
      logic [BW-1:0] d;
      int            beats;
      bit            ph;
      bit            done;
      oh = '0;
      oh[g] = 1'b1;
      @(negedge clk);
      set_eng(mask, len, base);
      ref_info_rdy_in = 1'b0;
      #1;
      chk("accept_rdy", eng_ref_info_rdy_out, oh);
      chk("idle_busy", busy_out, 0);
      chk("idle_info_vld", ref_info_valid_out, 0);
      @(negedge clk);
      eng_ref_info_valid_in = '0;
      ref_info_rdy_in = 1'b1;
      #1;
      chk("issue_vld", ref_info_valid_out, 1);
      chk("issue_addr", ref_addr_out, base + 25'(g*16));
      chk("issue_len", ref_length_out, len);
      chk("issue_grant", grant_id_out, g);
      chk("issue_busy", busy_out, 1);
      chk("issue_blk_vld", eng_ref_seq_block_valid_out, 0);
      beats = 0;
      ph = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         ref_info_rdy_in = 1'b0;
         rand_block(d);
         ref_seq_block_in = d;
         ref_seq_block_valid_in = 1'b1;
         eng_ref_seq_block_rdy_in = (toggle && !ph) ? '0 : oh;
         ph = !ph;
         #1;
         if (!busy_out) begin
            done = 1'b1;
         end else begin
            chk("blk_vld", eng_ref_seq_block_valid_out, oh);
            chk("blk_dat", eng_ref_seq_block_out, d);
            chk("blk_rdy", ref_seq_block_rdy_out, eng_ref_seq_block_rdy_in[g]);
            if (eng_ref_seq_block_rdy_in[g]) beats++;
         end
      end
      chk("txn_done_in_bound", done, 1);
      chk("beat_count", beats, len);
      chk("surplus_rdy", ref_seq_block_rdy_out, 0);
      chk("surplus_vld", eng_ref_seq_block_valid_out, 0);
      ref_seq_block_valid_in = 1'b0;
      eng_ref_seq_block_rdy_in = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      eng_ref_info_valid_in = '0;
      ref_seq_block_valid_in = 1'b0;
      ref_info_rdy_in = 1'b0;
      eng_ref_seq_block_rdy_in = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] mask;
      logic [24:0]  len;
      logic [24:0]  base;
      int           grant;
      bit           toggle;
   } vec_t;

   vec_t tbl[11];

   // Reference model state for random traffic
   int           m_phase, m_ptr, m_grant, m_left;
   logic [24:0]  m_addr, m_len;
   bit           rv[N];
   logic [24:0]  ra[N], rl[N];

   initial begin
      // ptr evolves 0 ->3 ->0 ->1 ->2 ->3 ->0 ->1 ->2 ->1 ->1 ->3 through the table
      tbl[0]  = '{4'b0100, 25'd3, 25'h100, 2, 1'b0};
      tbl[1]  = '{4'b1111, 25'd2, 25'h400, 3, 1'b0};
      tbl[2]  = '{4'b1111, 25'd2, 25'h400, 0, 1'b0};
      tbl[3]  = '{4'b1111, 25'd2, 25'h400, 1, 1'b0};
      tbl[4]  = '{4'b1111, 25'd2, 25'h400, 2, 1'b0};
      tbl[5]  = '{4'b1111, 25'd2, 25'h400, 3, 1'b0};
      tbl[6]  = '{4'b1111, 25'd2, 25'h400, 0, 1'b0};
      tbl[7]  = '{4'b0010, 25'd0, 25'h800, 1, 1'b0};
      tbl[8]  = '{4'b0011, 25'd1, 25'h900, 0, 1'b0};
      tbl[9]  = '{4'b0001, 25'd1, 25'hA00, 0, 1'b0};
      tbl[10] = '{4'b0100, 25'd4, 25'hB00, 2, 1'b1};

      #2;
      chk("rst_busy", busy_out, 0);
      chk("rst_info_vld", ref_info_valid_out, 0);
      chk("rst_grant", grant_id_out, 0);
      chk("rst_addr", ref_addr_out, 0);
      chk("rst_len", ref_length_out, 0);
      chk("rst_timeout", timeout_out, 0);
      chk("rst_blk_rdy", ref_seq_block_rdy_out, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int t = 0; t < 11; t++)
         do_txn(tbl[t].mask, tbl[t].len, tbl[t].base, tbl[t].grant, tbl[t].toggle);

      // Reset after the first of five beats; ptr is 3, so engine 0 wins.
      @(negedge clk);
      set_eng(4'b0001, 25'd5, 25'h40);
      #1 chk("rs_accept", eng_ref_info_rdy_out, 4'b0001);
      @(negedge clk);
      eng_ref_info_valid_in = '0;
      ref_info_rdy_in = 1'b1;
      @(negedge clk);
      ref_info_rdy_in = 1'b0;
      ref_seq_block_valid_in = 1'b1;
      eng_ref_seq_block_rdy_in = 4'b0001;
      #1 chk("rs_beat1_vld", eng_ref_seq_block_valid_out, 4'b0001);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rs_busy", busy_out, 0);
      chk("rs_blk_vld", eng_ref_seq_block_valid_out, 0);
      chk("rs_blk_rdy", ref_seq_block_rdy_out, 0);
      chk("rs_addr", ref_addr_out, 0);
      chk("rs_len", ref_length_out, 0);
      chk("rs_grant", grant_id_out, 0);
      chk("rs_info_vld", ref_info_valid_out, 0);
      chk("rs_blk_dat", eng_ref_seq_block_out, 0);
      @(negedge clk);
      rst = 1'b1;
      ref_seq_block_valid_in = 1'b0;
      eng_ref_seq_block_rdy_in = '0;
      do_txn(4'b1111, 25'd2, 25'h200, 0, 1'b0);

      // Random traffic against the reference model
      do_reset();
      m_phase = 0; m_ptr = 0; m_grant = 0; m_left = 0; m_addr = '0; m_len = '0;
      for (int i = 0; i < N; i++) begin rv[i] = 1'b0; ra[i] = '0; rl[i] = '0; end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [N-1:0]  e_rdy, e_bvld;
         logic          e_ivld, e_brdy, f;
         logic [BW-1:0] e_dat, d;
         int            w;
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!rv[i] && $urandom_range(3) == 0) begin
               rv[i] = 1'b1;
               ra[i] = 25'($urandom());
               rl[i] = 25'($urandom_range(4));
            end
            eng_ref_info_valid_in[i]      = rv[i];
            eng_ref_addr_in[25*i +: 25]   = ra[i];
            eng_ref_length_in[25*i +: 25] = rl[i];
         end
         ref_info_rdy_in = 1'($urandom_range(1));
         ref_seq_block_valid_in = 1'($urandom_range(1));
         rand_block(d);
         ref_seq_block_in = d;
         eng_ref_seq_block_rdy_in = N'($urandom());
         #1;
         e_rdy = '0; e_bvld = '0; e_ivld = 1'b0; e_brdy = 1'b0; e_dat = '0; f = 1'b0; w = 0;
         if (m_phase == 0) begin
            for (int k = 0; k < N; k++)
               if (!f && rv[(m_ptr + k) % N]) begin f = 1'b1; w = (m_ptr + k) % N; end
            if (f) e_rdy[w] = 1'b1;
         end else if (m_phase == 1) begin
            e_ivld = 1'b1;
            chk("r_addr", ref_addr_out, m_addr);
            chk("r_len", ref_length_out, m_len);
         end else begin
            e_bvld[m_grant] = ref_seq_block_valid_in;
            e_brdy = eng_ref_seq_block_rdy_in[m_grant];
            e_dat = d;
         end
         chk("r_info_rdy", eng_ref_info_rdy_out, e_rdy);
         chk("r_info_vld", ref_info_valid_out, e_ivld);
         chk("r_blk_vld", eng_ref_seq_block_valid_out, e_bvld);
         chk("r_blk_rdy", ref_seq_block_rdy_out, e_brdy);
         chk("r_blk_dat", eng_ref_seq_block_out, e_dat);
         chk("r_busy", busy_out, m_phase != 0);
         chk("r_grant", grant_id_out, m_grant);
         chk("r_timeout", timeout_out, 0);
         if (m_phase == 0) begin
            if (f) begin
               m_grant = w; m_addr = ra[w]; m_len = rl[w]; rv[w] = 1'b0; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (ref_info_rdy_in) begin
               if (m_len == 0) begin m_phase = 0; m_ptr = (m_grant + 1) % N; end
               else begin m_left = int'(m_len); m_phase = 2; end
            end
         end else if (ref_seq_block_valid_in && eng_ref_seq_block_rdy_in[m_grant]) begin
            m_left--;
            if (m_left == 0) begin m_phase = 0; m_ptr = (m_grant + 1) % N; end
         end
      end

`ifdef REF_ARB_WATCHDOG_EN
      // Reader never delivers: watchdog must abandon the grant and advance ptr.
      do_reset();
      @(negedge clk);
      set_eng(4'b0010, 25'd2, 25'h300);
      @(negedge clk);
      eng_ref_info_valid_in = '0;
      ref_info_rdy_in = 1'b1;
      begin
         bit idle_seen;
         idle_seen = 1'b0;
         for (int c = 0; c < 70000 && !idle_seen; c++) begin
            @(negedge clk);
            ref_info_rdy_in = 1'b0;
            ref_seq_block_valid_in = 1'b0;
            eng_ref_seq_block_rdy_in = 4'b0010;
            #1;
            if (!busy_out) idle_seen = 1'b1;
         end
         chk("wd_left_stream", idle_seen, 1);
      end
      chk("wd_timeout", timeout_out, 1);
      set_eng(4'b1111, 25'd1, 25'h0);
      #1 chk("wd_next_grant", eng_ref_info_rdy_out, 4'b0100);
      @(negedge clk);
      eng_ref_info_valid_in = '0;
      repeat (3) @(negedge clk);
      chk("wd_sticky", timeout_out, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
